// File: rtl/axi_aw_arbiter_m2_if.sv
// Request/handshake bundle between the two AW masters' mux and the AW/W arbiter.
// master modport is the arbiter side; slave modport is the mux/slave side.
interface axi_aw_arbiter_m2_if #(parameter int WIDTH_CID = 2);
  logic [1:0]           REQ;
  logic                 AWVALID_S;
  logic                 AWREADY_S;
  logic                 WVALID_S;
  logic                 WREADY_S;
  logic                 WLAST_S;
  logic [1:0]           GRANT;
  logic [WIDTH_CID-1:0] GRANT_ID;
  logic                 BUSY;

  modport master (
    input  REQ, AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, WLAST_S,
    output GRANT, GRANT_ID, BUSY
  );

  modport slave (
    output REQ, AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, WLAST_S,
    input  GRANT, GRANT_ID, BUSY
  );
endinterface

// File: rtl/axi_aw_arbiter_m2.sv
// Two-master AXI write-channel arbiter: holds the grant across AW and W until both complete.
// Define AXI_ARB_FIXED_PRIORITY_EN for fixed priority (master 0 wins ties); default is round-robin.
module axi_aw_arbiter_m2 #(
  parameter int WIDTH_CID = 2
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_aw_arbiter_m2_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic       wdone;
  logic       last;      // 1: master 1 was granted last
  logic [1:0] win;
  logic       aw_hs, wl_hs;

  assign aw_hs = bus.AWVALID_S & bus.AWREADY_S;
  assign wl_hs = bus.WVALID_S & bus.WREADY_S & bus.WLAST_S;

  always_comb begin
    win = 2'b00;
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    if (bus.REQ[0])      win = 2'b01;
    else if (bus.REQ[1]) win = 2'b10;
`else
    if (bus.REQ == 2'b11) win = last ? 2'b01 : 2'b10;
    else if (bus.REQ[0])  win = 2'b01;
    else if (bus.REQ[1])  win = 2'b10;
`endif
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      wdone        <= 1'b0;
      last         <= 1'b1;
      bus.GRANT    <= 2'b00;
      bus.GRANT_ID <= '0;
      bus.BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win != 2'b00) begin
            state        <= ADDR;
            bus.GRANT    <= win;
            bus.GRANT_ID <= win[1] ? WIDTH_CID'(1) : '0;
            bus.BUSY     <= 1'b1;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            if (wdone || wl_hs) begin
              state        <= IDLE;
              wdone        <= 1'b0;
              last         <= bus.GRANT[1];
              bus.GRANT    <= 2'b00;
              bus.GRANT_ID <= '0;
              bus.BUSY     <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else if (wl_hs) begin
            wdone <= 1'b1;
          end
        end
        DATA: begin
          if (wl_hs) begin
            state        <= IDLE;
            wdone        <= 1'b0;
            last         <= bus.GRANT[1];
            bus.GRANT    <= 2'b00;
            bus.GRANT_ID <= '0;
            bus.BUSY     <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          wdone        <= 1'b0;
          bus.GRANT    <= 2'b00;
          bus.GRANT_ID <= '0;
          bus.BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_arbiter_m2.sv
// Directed bench for axi_aw_arbiter_m2: single, tied, early-W, REQ-switch and reset-mid-burst cases.
module tb_axi_aw_arbiter_m2;
  logic ACLK = 1'b0;
  logic ARESETn;
  int   total = 0;
  int   bad   = 0;

  axi_aw_arbiter_m2_if #(.WIDTH_CID(2)) bus ();
  axi_aw_arbiter_m2 #(.WIDTH_CID(2)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic hs(input logic aw, input logic w, input logic wl);
    bus.AWVALID_S = aw; bus.AWREADY_S = aw;
    bus.WVALID_S  = w;  bus.WREADY_S  = w;
    bus.WLAST_S   = wl;
  endtask

  task automatic chk_g(input string tag, input logic [1:0] g);
    chk({tag, "_gnt"},  {6'd0, bus.GRANT}, {6'd0, g});
    chk({tag, "_id"},   {6'd0, bus.GRANT_ID}, {6'd0, (g == 2'b10) ? 2'd1 : 2'd0});
    chk({tag, "_busy"}, {7'd0, bus.BUSY}, {7'd0, g != 2'b00});
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    #1;
    chk_g("rst", 2'b00);
    tick();
    ARESETn = 1'b1;
  endtask

  logic [1:0] rr_exp [3];

  initial begin
    bus.REQ = 2'b00;
    hs(0, 0, 0);
    ARESETn = 1'b1;
    #2;
    do_reset();

    // idle with no request stays ungranted
    tick(); chk_g("idle", 2'b00);

    // single master, AW then 4 W beats
    bus.REQ = 2'b01;
    tick(); chk_g("b1_grant", 2'b01);
    tick(); chk_g("b1_wait", 2'b01);
    hs(1, 0, 0);
    tick(); chk_g("b1_aw", 2'b01);
    for (int i = 0; i < 3; i++) begin
      hs(0, 1, 0);
      tick(); chk_g("b1_beat", 2'b01);
    end
    hs(0, 1, 1); bus.REQ = 2'b00;
    tick(); chk_g("b1_rel", 2'b00);
    hs(0, 0, 0);
    tick(); chk_g("b1_idle", 2'b00);

    // tied requests over three single-beat bursts
    do_reset();
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01;
`else
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
`endif
    bus.REQ = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_g("tie_grant", rr_exp[i]);
      hs(1, 1, 1);
      tick(); chk_g("tie_rel", 2'b00);
      hs(0, 0, 0);
    end
    bus.REQ = 2'b00;
    tick(); chk_g("tie_idle", 2'b00);

    // W-last two cycles before AW
    bus.REQ = 2'b01;
    tick(); chk_g("ew_grant", 2'b01);
    hs(0, 1, 1);
    tick(); chk_g("ew_wl", 2'b01);
    hs(0, 0, 0);
    tick(); chk_g("ew_hold", 2'b01);
    hs(1, 0, 0); bus.REQ = 2'b00;
    tick(); chk_g("ew_rel", 2'b00);
    hs(0, 0, 0);
    tick(); chk_g("ew_idle", 2'b00);

    // REQ switches to master 1 while master 0 is in DATA
    bus.REQ = 2'b01;
    tick(); chk_g("sw_grant", 2'b01);
    hs(1, 0, 0);
    tick(); chk_g("sw_aw", 2'b01);
    hs(0, 0, 0); bus.REQ = 2'b10;
    tick(); chk_g("sw_hold0", 2'b01);
    tick(); chk_g("sw_hold1", 2'b01);
    hs(0, 1, 1);
    tick(); chk_g("sw_rel", 2'b00);
    hs(0, 0, 0);
    tick(); chk_g("sw_m1", 2'b10);

    // reset during DATA with master 1 granted
    hs(1, 0, 0);
    tick(); chk_g("rm_data", 2'b10);
    hs(0, 0, 0);
    bus.REQ = 2'b11;
    #2;
    ARESETn = 1'b0;
    #1;
    chk_g("rm_async", 2'b00);
    tick(); chk_g("rm_held", 2'b00);
    ARESETn = 1'b1;
    tick(); chk_g("rm_first", 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
